// File: rtl/vec_stream_pkg.sv
// Shared types and default geometry for the chunked vector stages (sequencer, bias add, ReLU).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vec_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_e;

    // Default vector geometry, shared with the bias and ReLU datapaths.
    localparam int unsigned WORKING_REGS  = 4;
    localparam int unsigned IN_VEC_LENGTH = 16;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-Modulus counter with synchronous clear; wrap flags the increment that returns to 0.
// Latency: count updates one cycle after inc/clear; wrap is combinational from inc and count.
// Backpressure: none; the owner gates inc.
// Ports: clk/rst_n (async active-low), inc, clear (wins over inc), count, wrap.
module wrap_counter #(
    parameter  int unsigned Modulus = 4,
    localparam int unsigned CntW    = (Modulus > 1) ? $clog2(Modulus) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            clear,
    output logic [CntW-1:0] count,
    output logic            wrap
);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // With Modulus = 1 every increment wraps and count stays at 0.
    assign wrap  = inc && (count_q == CntW'(Modulus - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vec_stream_ctrl.sv
// Sequencer for chunked vector stages: pops input chunks, drives parameter address, pushes results.
// Latency: issue (in_rd_en_out) at t gives the output write at t+1; one chunk per cycle sustained.
// Backpressure: out_afull_in or in_empty_in stalls issue in the same cycle; abort_in stops issue.
// Ports: start/num_vecs/abort job control; in FIFO empty/pop; out FIFO afull/push;
//        param_addr_out (chunk index); chunk_last/vec_done/done pulses; busy and vecs_left status.
module vec_stream_ctrl
    import vec_stream_pkg::*;
#(
    parameter  int unsigned InVecLength   = IN_VEC_LENGTH,
    parameter  int unsigned WorkingRegs   = WORKING_REGS,
    parameter  int unsigned ChunksPerVec  = InVecLength / WorkingRegs,
    parameter  int unsigned VecCountWidth = 16,
    localparam int unsigned AddrW         = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     start_in,
    input  logic [VecCountWidth-1:0] num_vecs_in,
    input  logic                     abort_in,
    input  logic                     in_empty_in,
    output logic                     in_rd_en_out,
    input  logic                     out_afull_in,
    output logic                     out_wr_en_out,
    output logic [AddrW-1:0]         param_addr_out,
    output logic                     chunk_last_out,
    output logic                     vec_done_out,
    output logic                     done_out,
    output logic                     busy_out,
    output logic [VecCountWidth-1:0] vecs_left_out
);

    ctrl_state_e              state_q, state_d;
    logic [VecCountWidth-1:0] vecs_left_q, vecs_left_d;
    logic                     wr_q, wr_d;
    logic                     last_q, last_d;
    logic                     zero_done_q, zero_done_d;

    logic                     issue;
    logic                     job_start;
    logic                     chunk_wrap;
    logic [AddrW-1:0]         chunk_idx;

    // out_afull_in means at most one free slot, which is reserved for the write in flight.
    assign issue     = (state_q == RUN) && !in_empty_in && !out_afull_in && !abort_in;
    assign job_start = (state_q == IDLE) && start_in && (num_vecs_in != '0);

    wrap_counter #(
        .Modulus (ChunksPerVec)
    ) u_chunk_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (issue),
        .clear (job_start),
        .count (chunk_idx),
        .wrap  (chunk_wrap)
    );

    always_comb begin
        state_d     = state_q;
        vecs_left_d = vecs_left_q;
        zero_done_d = 1'b0;
        // The write stage simply mirrors the issue one cycle later.
        wr_d        = issue;
        last_d      = chunk_wrap;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (num_vecs_in != '0) begin
                        vecs_left_d = num_vecs_in;
                        state_d     = RUN;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (chunk_wrap) begin
                    vecs_left_d = vecs_left_q - VecCountWidth'(1);
                    if (vecs_left_q == VecCountWidth'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            vecs_left_q <= '0;
            wr_q        <= 1'b0;
            last_q      <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vecs_left_q <= vecs_left_d;
            wr_q        <= wr_d;
            last_q      <= last_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign in_rd_en_out   = issue;
    assign param_addr_out = chunk_idx;
    assign out_wr_en_out  = wr_q;
    assign chunk_last_out = last_q;
    assign vec_done_out   = wr_q && last_q;
    // The final vector's write lands in DRAIN; an abort there still suppresses job completion.
    assign done_out       = zero_done_q || ((state_q == DRAIN) && wr_q && last_q && !abort_in);
    assign busy_out       = (state_q != IDLE);
    assign vecs_left_out  = vecs_left_q;

endmodule

// File: tb/tb_vec_stream_ctrl.sv
module tb_vec_stream_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        start_in = 1'b0;
    logic [15:0] num_vecs_in = '0;
    logic        abort_in = 1'b0;
    logic        in_empty_in = 1'b0;
    logic        in_rd_en_out;
    logic        out_afull_in = 1'b0;
    logic        out_wr_en_out;
    logic [1:0]  param_addr_out;
    logic        chunk_last_out;
    logic        vec_done_out;
    logic        done_out;
    logic        busy_out;
    logic [15:0] vecs_left_out;

    int total = 0;
    int bad   = 0;

    vec_stream_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .num_vecs_in    (num_vecs_in),
        .abort_in       (abort_in),
        .in_empty_in    (in_empty_in),
        .in_rd_en_out   (in_rd_en_out),
        .out_afull_in   (out_afull_in),
        .out_wr_en_out  (out_wr_en_out),
        .param_addr_out (param_addr_out),
        .chunk_last_out (chunk_last_out),
        .vec_done_out   (vec_done_out),
        .done_out       (done_out),
        .busy_out       (busy_out),
        .vecs_left_out  (vecs_left_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [15:0] num;
        logic        abort;
        logic        empty;
        logic        afull;
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic        last;
        logic        vd;
        logic        done;
        logic        busy;
        logic [15:0] left;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic rst_n, input logic start, input int num, input logic abort,
                     input logic empty, input logic afull, input logic rd, input logic wr,
                     input int addr, input logic last, input logic vd, input logic done,
                     input logic busy, input int left);
        vec_t r;
        r.rst_n = rst_n; r.start = start; r.num = 16'(num); r.abort = abort;
        r.empty = empty; r.afull = afull; r.rd = rd; r.wr = wr; r.addr = 2'(addr);
        r.last = last; r.vd = vd; r.done = done; r.busy = busy; r.left = 16'(left);
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    // One cycle of the hand-written sequences; tallies pops, pushes and job-done pulses.
    int n_rd, n_wr, n_done;
    task automatic cyc(input logic start, input int num, input logic abort);
        @(negedge clk_in);
        start_in    = start;
        num_vecs_in = 16'(num);
        abort_in    = abort;
        in_empty_in = 1'b0;
        out_afull_in = 1'b0;
        #1;
        n_rd   += int'(in_rd_en_out);
        n_wr   += int'(out_wr_en_out);
        n_done += int'(done_out);
    endtask

    initial begin
        // rst start num abort empty afull | rd wr addr last vd done busy left
        // reset
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // basic job: 2 vectors, start mid-run must be ignored
        v(1,1,2,0,0,0, 0,0,0,0,0,0,0,0);
        v(1,0,0,0,0,0, 1,0,0,0,0,0,1,2);
        v(1,0,0,0,0,0, 1,1,1,0,0,0,1,2);
        v(1,1,7,0,0,0, 1,1,2,0,0,0,1,2);
        v(1,0,0,0,0,0, 1,1,3,0,0,0,1,2);
        v(1,0,0,0,0,0, 1,1,0,1,1,0,1,1);
        v(1,0,0,0,0,0, 1,1,1,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,1,2,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,1,3,0,0,0,1,1);
        v(1,0,0,0,0,0, 0,1,0,1,1,1,1,0);
        v(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // zero-length job
        v(1,1,0,0,0,0, 0,0,0,0,0,0,0,0);
        v(1,0,0,0,0,0, 0,0,0,0,0,1,0,0);
        v(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // backpressure: afull for 3 cycles mid-vector
        v(1,1,1,0,0,0, 0,0,0,0,0,0,0,0);
        v(1,0,0,0,0,0, 1,0,0,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,1,1,0,0,0,1,1);
        v(1,0,0,0,0,1, 0,1,2,0,0,0,1,1);
        v(1,0,0,0,0,1, 0,0,2,0,0,0,1,1);
        v(1,0,0,0,0,1, 0,0,2,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,0,2,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,1,3,0,0,0,1,1);
        v(1,0,0,0,0,0, 0,1,0,1,1,1,1,0);
        v(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // starvation: empty every other cycle
        v(1,1,1,0,0,0, 0,0,0,0,0,0,0,0);
        v(1,0,0,0,1,0, 0,0,0,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,0,0,0,0,0,1,1);
        v(1,0,0,0,1,0, 0,1,1,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,0,1,0,0,0,1,1);
        v(1,0,0,0,1,0, 0,1,2,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,0,2,0,0,0,1,1);
        v(1,0,0,0,1,0, 0,1,3,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,0,3,0,0,0,1,1);
        v(1,0,0,0,1,0, 0,1,0,1,1,1,1,0);
        v(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        // abort after 5 issues of a 3-vector job
        v(1,1,3,0,0,0, 0,0,0,0,0,0,0,0);
        v(1,0,0,0,0,0, 1,0,0,0,0,0,1,3);
        v(1,0,0,0,0,0, 1,1,1,0,0,0,1,3);
        v(1,0,0,0,0,0, 1,1,2,0,0,0,1,3);
        v(1,0,0,0,0,0, 1,1,3,0,0,0,1,3);
        v(1,0,0,0,0,0, 1,1,0,1,1,0,1,2);
        v(1,0,0,1,0,0, 0,1,1,0,0,0,1,2);
        v(1,0,0,0,0,0, 0,0,1,0,0,0,0,2);
        v(1,0,0,0,0,0, 0,0,1,0,0,0,0,2);
        // async reset mid-job, then restart with one vector
        v(1,1,2,0,0,0, 0,0,1,0,0,0,0,2);
        v(1,0,0,0,0,0, 1,0,0,0,0,0,1,2);
        v(1,0,0,0,0,0, 1,1,1,0,0,0,1,2);
        v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        v(1,1,1,0,0,0, 0,0,0,0,0,0,0,0);
        v(1,0,0,0,0,0, 1,0,0,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,1,1,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,1,2,0,0,0,1,1);
        v(1,0,0,0,0,0, 1,1,3,0,0,0,1,1);
        v(1,0,0,0,0,0, 0,1,0,1,1,1,1,0);
        v(1,0,0,0,0,0, 0,0,0,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_in);
            rst_n_in     = tbl[i].rst_n;
            start_in     = tbl[i].start;
            num_vecs_in  = tbl[i].num;
            abort_in     = tbl[i].abort;
            in_empty_in  = tbl[i].empty;
            out_afull_in = tbl[i].afull;
            #1;
            chk("rd_en",     i, 16'(in_rd_en_out),   16'(tbl[i].rd));
            chk("wr_en",     i, 16'(out_wr_en_out),  16'(tbl[i].wr));
            chk("addr",      i, 16'(param_addr_out), 16'(tbl[i].addr));
            chk("last",      i, 16'(chunk_last_out), 16'(tbl[i].last));
            chk("vec_done",  i, 16'(vec_done_out),   16'(tbl[i].vd));
            chk("done",      i, 16'(done_out),       16'(tbl[i].done));
            chk("busy",      i, 16'(busy_out),       16'(tbl[i].busy));
            chk("vecs_left", i, vecs_left_out,       tbl[i].left);
        end

        // Abort arriving with the final-chunk issue: the chunk must not be issued.
        n_rd = 0; n_wr = 0; n_done = 0;
        cyc(1'b1, 1, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b1);
        chk("abort_last_rd", 0, 16'(in_rd_en_out), 16'd0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        chk("abort_last_pops",   0, 16'(n_rd),     16'd3);
        chk("abort_last_writes", 0, 16'(n_wr),     16'd3);
        chk("abort_last_done",   0, 16'(n_done),   16'd0);
        chk("abort_last_busy",   0, 16'(busy_out), 16'd0);
        chk("abort_last_left",   0, vecs_left_out, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
